tour_move_seq: RTL and testbench
================================

// Module: tour_move_seq
// PURPOSE
//  Parametrised tour command sequencer between TourLogic and cmd_proc. On start_tour it walks
//  NUM_MOVES one-hot knight moves. Each move becomes a vertical then a horizontal cmd_proc
//  move command. Otherwise UART commands pass straight through. Adds a registered move fetch,
//  illegal-move detection, external abort, and busy/done/error status.
// PARAMETERS
//  NUM_MOVES  24          moves per tour (mv_indx 0..NUM_MOVES-1)
//  IDX_W      $clog2(NUM_MOVES)  width of mv_indx
//  RESP_UART  8'hA5       resp while UART owns cmd path
//  RESP_TOUR  8'h5A       resp while tour owns cmd path
//  WDOG_CYC   25_000_000  cycles allowed per component before timeout (TOUR_WDOG_EN only)
// PORTS
//  clk           in   1      50MHz clock
//  rst_n         in   1      asynchronous, active-low reset
//  start_tour    in   1      pulse: begin tour (ignored unless IDLE)
//  abort         in   1      pulse: end tour at next safe point
//  move          in   8      one-hot move for mv_indx, valid 1 clk after mv_indx changes
//  mv_indx       out  IDX_W  move address, registered
//  cmd_UART      in   16     command from UART_wrapper
//  cmd_rdy_UART  in   1      UART command valid
//  cmd           out  16     muxed command to cmd_proc
//  cmd_rdy       out  1      muxed command valid
//  clr_cmd_rdy   in   1      cmd_proc accepted cmd
//  send_resp     in   1      cmd_proc finished cmd
//  resp          out  8      RESP_TOUR when tour owns path, else RESP_UART
//  tour_busy     out  1      high in every non-IDLE state
//  tour_done     out  1      1-clk pulse: last move completed
//  tour_err      out  1      sticky: illegal move/timeout; cleared by next start_tour
// BEHAVIOUR
//  Reset: state IDLE, mv_indx=0, mv_reg=0, tour_err=0, tour_done=0; UART path selected.
//  Tour cmd = {3'b010, fanfare, heading[7:0], len[3:0]}; fanfare = (len==1).
//  Heading codes: N=8'h00, S=8'h7F, W=8'h3F, E=8'hBF.
//  Decode of mv_reg bit k -> vert/hor components:
//   0:N2/E1  1:N2/W1  2:N1/W2  3:S1/W2  4:S2/W1  5:S2/E1  6:S1/E2  7:N1/E2
//  Legal move: mv_reg has exactly one bit set ($onehot); anything else is illegal.
//  FSM states: IDLE, FETCH, VERT, VERT_WAIT, HOR, HOR_WAIT.
//   IDLE: start_tour -> mv_indx<=0, tour_err<=0, go FETCH.
//   FETCH: mv_reg<=move (1 clk). Go VERT.
//   VERT: illegal mv_reg -> tour_err<=1, go IDLE, no cmd_rdy. Else cmd_rdy=1 with vert cmd;
//    clr_cmd_rdy -> VERT_WAIT.
//   VERT_WAIT: send_resp -> HOR.
//   HOR: cmd_rdy=1 with hor cmd; clr_cmd_rdy -> HOR_WAIT.
//   HOR_WAIT, on send_resp:
//    last move (mv_indx==NUM_MOVES-1) -> pulse tour_done, go IDLE;
//    else -> mv_indx++, go FETCH.
//  cmd_rdy is combinational from state; cmd is stable from cmd_rdy rise through send_resp.
//  Tour path owns cmd/cmd_rdy/resp in FETCH..HOR_WAIT; cmd_rdy is 0 in FETCH.
//  UART commands arriving during a tour are not forwarded and are not buffered.
//  Latency: start_tour -> first cmd_rdy = 2 clks (IDLE->FETCH->VERT).
//  Latency: HOR_WAIT send_resp -> next cmd_rdy = 2 clks.
//  Abort: latched into abort_pend.
//   abort_pend in VERT/HOR (cmd not yet accepted) -> IDLE immediately.
//   abort_pend in *_WAIT -> IDLE on send_resp, never mid-command.
//   Abort has priority over the FETCH/HOR transition. No tour_done pulse; tour_err unchanged.
//  Simultaneous clr_cmd_rdy and send_resp in VERT/HOR: clr_cmd_rdy only, send_resp ignored.
//  start_tour while busy: ignored. start_tour together with abort in IDLE: start wins, abort dropped.
//  rst_n mid-tour: immediate IDLE, all registers to reset values.
// CONFIGURATION
//  TOUR_WDOG_EN defined:
//   wdog counter clears on entering each *_WAIT state and counts there.
//   Reaching WDOG_CYC-1 -> tour_err<=1, go IDLE.
//  TOUR_WDOG_EN undefined: no counter; WDOG_CYC unused; *_WAIT waits indefinitely.
// STRUCTURE
//  Package tour_pkg holds:
//   typedef tour_state_t;
//   localparams HDG_N/S/E/W, CMD_MOVE=3'b010;
//   function move_decode(mv, is_hor) -> {fanfare, heading, len}.
//  No sub-module: the decode is a pure package function; one FSM plus counters.
// TESTING
//  Full 24-move tour, bench model of cmd_proc:
//   first cmd 16'h4002 (move 0 vert), then 16'h5BF1 (move 0 hor);
//   48 cmd_rdy pulses total; tour_done pulses once; resp=5A while busy, A5 after.
//  Illegal move 8'b0000_0011 at mv_indx=5:
//   no cmd_rdy for that index, tour_err=1, IDLE, mv_indx=5.
//  Abort asserted in VERT_WAIT:
//   FSM stays until send_resp, then IDLE; no HOR cmd issued; tour_done=0.
//  UART passthrough when idle: cmd_UART=16'h2345 with cmd_rdy_UART -> cmd=16'h2345, cmd_rdy=1.
//   Same stimulus while busy -> not forwarded.
//  Reset asserted in HOR_WAIT -> mv_indx=0, tour_busy=0, cmd_rdy follows cmd_rdy_UART next clk.
//  TOUR_WDOG_EN, WDOG_CYC=16: withhold send_resp -> tour_err=1 exactly 16 clks into VERT_WAIT.

Source files
------------

// File: rtl/tour_pkg.sv
// tour_pkg: sequencer states, heading codes and the knight-move decode.
// Shared by tour_move_seq; pure types and functions only.
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    VERT,
    VERT_WAIT,
    HOR,
    HOR_WAIT
  } tour_state_t;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [2:0] CMD_MOVE = 3'b010;

  // Returns {fanfare, heading, len}; non-one-hot input yields len 0.
  function automatic logic [12:0] move_decode(
    input logic [7:0] mv,
    input logic       is_hor
  );
    logic [7:0] hdg;
    logic [3:0] len;
    hdg = HDG_N;
    len = 4'd0;
    if (!is_hor) begin
      case (mv)
        8'h01, 8'h02: begin hdg = HDG_N; len = 4'd2; end
        8'h04, 8'h80: begin hdg = HDG_N; len = 4'd1; end
        8'h08, 8'h40: begin hdg = HDG_S; len = 4'd1; end
        8'h10, 8'h20: begin hdg = HDG_S; len = 4'd2; end
        default: ;
      endcase
    end else begin
      case (mv)
        8'h01, 8'h20: begin hdg = HDG_E; len = 4'd1; end
        8'h02, 8'h10: begin hdg = HDG_W; len = 4'd1; end
        8'h04, 8'h08: begin hdg = HDG_W; len = 4'd2; end
        8'h40, 8'h80: begin hdg = HDG_E; len = 4'd2; end
        default: ;
      endcase
    end
    return {(len == 4'd1), hdg, len};
  endfunction

endpackage

// File: rtl/tour_move_seq.sv
// tour_move_seq: knight-tour command sequencer muxed with the UART path.
// Optional per-component watchdog is enabled by defining TOUR_WDOG_EN.
module tour_move_seq
  import tour_pkg::*;
#(
  parameter int         NUM_MOVES = 24,
  parameter int         IDX_W     = $clog2(NUM_MOVES),
  parameter logic [7:0] RESP_UART = 8'hA5,
  parameter logic [7:0] RESP_TOUR = 8'h5A,
  parameter int         WDOG_CYC  = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic             abort,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             tour_done,
  output logic             tour_err
);

  tour_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       mv_q, mv_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             pend_q, pend_d;
  logic             tour_rdy;
  logic             is_hor;
  logic             last_mv;
  logic             wdog_to;
  logic [15:0]      tour_cmd;

`ifdef TOUR_WDOG_EN
  localparam int WdW = $clog2(WDOG_CYC);
  logic [WdW-1:0] wdog_q, wdog_d;

  // Entry to a wait state is always from VERT/HOR, where it is held at 0.
  always_comb begin
    wdog_d = '0;
    if (state_q == VERT_WAIT || state_q == HOR_WAIT)
      wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end

  assign wdog_to = (wdog_q == WdW'(WDOG_CYC - 1));
`else
  assign wdog_to = 1'b0;
`endif

  assign last_mv = (idx_q == IDX_W'(NUM_MOVES - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mv_d     = mv_q;
    err_d    = err_q;
    done_d   = 1'b0;
    pend_d   = pend_q | abort;
    tour_rdy = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_tour) begin
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        mv_d    = move;
        state_d = pend_q ? IDLE : VERT;
      end
      VERT: begin
        if (pend_q) begin
          state_d = IDLE;
        end else if (!$onehot(mv_q)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tour_rdy = 1'b1;
          if (clr_cmd_rdy) state_d = VERT_WAIT;
        end
      end
      VERT_WAIT: begin
        if (send_resp) begin
          state_d = pend_q ? IDLE : HOR;
        end else if (wdog_to) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HOR: begin
        if (pend_q) begin
          state_d = IDLE;
        end else begin
          tour_rdy = 1'b1;
          if (clr_cmd_rdy) state_d = HOR_WAIT;
        end
      end
      HOR_WAIT: begin
        if (send_resp) begin
          if (pend_q) begin
            state_d = IDLE;
          end else if (last_mv) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end else if (wdog_to) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A pending abort never outlives the tour, nor is one taken in IDLE.
    if (state_q == IDLE || state_d == IDLE) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mv_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mv_q    <= mv_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign is_hor    = (state_q == HOR) || (state_q == HOR_WAIT);
  assign tour_cmd  = {CMD_MOVE, move_decode(mv_q, is_hor)};
  assign tour_busy = (state_q != IDLE);

  assign cmd       = tour_busy ? tour_cmd  : cmd_UART;
  assign cmd_rdy   = tour_busy ? tour_rdy  : cmd_rdy_UART;
  assign resp      = tour_busy ? RESP_TOUR : RESP_UART;
  assign mv_indx   = idx_q;
  assign tour_done = done_q;
  assign tour_err  = err_q;

endmodule

// File: tb/tb_tour_move_seq.sv
// tb_tour_move_seq: randomized cmd_proc/TourLogic environment for tour_move_seq.
// Expected commands come from knight displacement arithmetic in the bench.
module tb_tour_move_seq;

  localparam int N = 24;
  localparam int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  localparam int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0;
  logic        cmd_rdy_UART = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;
  logic        tour_busy;
  logic        tour_done;
  logic        tour_err;

  logic [7:0]  tbl [N];
  int          checks = 0;
  int          errors = 0;
  int          rdy_pulses = 0;
  int          done_pulses = 0;
  logic        rdy_prev = 1'b0;

  always #10 clk = ~clk;

  assign move = (int'(mv_indx) < N) ? tbl[mv_indx] : 8'h00;

  tour_move_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .abort        (abort),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp),
    .tour_busy    (tour_busy),
    .tour_done    (tour_done),
    .tour_err     (tour_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Vertical leg from dy, horizontal from dx; sign picks the heading.
  function automatic logic [15:0] exp_cmd(input logic [7:0] mv,
                                          input bit hor);
    int k, d;
    logic [7:0] h;
    logic [3:0] l;
    k = 0;
    for (int i = 0; i < 8; i++) if (mv[i]) k = i;
    d = hor ? DX[k] : DY[k];
    if (hor) h = (d > 0) ? 8'hBF : 8'h3F;
    else     h = (d > 0) ? 8'h00 : 8'h7F;
    l = 4'((d < 0) ? -d : d);
    return {3'b010, (l == 4'd1), h, l};
  endfunction

  // Per-cycle output checks, sampled clear of both clock edges.
  always begin
    @(posedge clk);
    #2;
    if (rst_n) begin
      chk("resp", {24'h0, resp}, tour_busy ? 32'h5A : 32'hA5);
      if (!tour_busy) begin
        chk("pass_cmd", {16'h0, cmd}, {16'h0, cmd_UART});
        chk("pass_rdy", {31'h0, cmd_rdy}, {31'h0, cmd_rdy_UART});
      end
      if (tour_busy && cmd_rdy && !rdy_prev) rdy_pulses++;
      if (tour_done) done_pulses++;
      rdy_prev = tour_busy && cmd_rdy;
    end
  end

  // cmd_proc model: wait for cmd_rdy, accept, hold, then send_resp.
  task automatic serve(input logic [15:0] expc, input int exp_lat,
                       input bit do_abort, input string nm,
                       output logic [15:0] got);
    int lat, n;
    lat = 0;
    do begin
      @(negedge clk);
      start_tour = 1'b0;
      send_resp  = 1'b0;
      abort      = 1'b0;
      cmd_UART     = 16'($urandom);
      cmd_rdy_UART = 1'($urandom_range(0, 1));
      lat++;
    end while (!cmd_rdy && lat < 20);
    got = cmd;
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_cmd"}, {16'h0, cmd}, {16'h0, expc});
    clr_cmd_rdy = 1'b1;
    send_resp   = ($urandom_range(0, 3) == 0);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    chk({nm, "_drop"}, {31'h0, cmd_rdy}, 32'h0);
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      abort        = (i == 0) && do_abort;
      start_tour   = ($urandom_range(0, 3) == 0);
      cmd_UART     = 16'h2345;
      cmd_rdy_UART = 1'b1;
      @(negedge clk);
      chk({nm, "_hold"}, {15'h0, cmd_rdy, cmd}, {15'h0, 1'b0, got});
      chk({nm, "_busy"}, {31'h0, tour_busy}, 32'h1);
    end
    abort      = 1'b0;
    start_tour = 1'b0;
    send_resp  = 1'b1;
  endtask

  task automatic fill_tbl();
    for (int i = 0; i < N; i++)
      tbl[i] = 8'h01 << $urandom_range(0, 7);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] got;
    int dp;
    fill_tbl();
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, tour_busy}, 32'h0);
    chk("rst_indx", {27'h0, mv_indx}, 32'h0);
    chk("rst_err", {31'h0, tour_err}, 32'h0);
    chk("rst_done", {31'h0, tour_done}, 32'h0);
    rst_n = 1'b1;

    // UART passthrough while idle
    cmd_UART = 16'h2345;
    cmd_rdy_UART = 1'b1;
    @(negedge clk);
    chk("uart_cmd", {16'h0, cmd}, 32'h2345);
    chk("uart_rdy", {31'h0, cmd_rdy}, 32'h1);
    cmd_rdy_UART = 1'b0;

    // Full tour
    tbl[0] = 8'h01;
    rdy_pulses = 0;
    done_pulses = 0;
    @(negedge clk);
    start_tour = 1'b1;
    for (int m = 0; m < N; m++) begin
      serve(exp_cmd(tbl[m], 0), 2, 0, "vert", got);
      if (m == 0) chk("first_vert", {16'h0, got}, 32'h4002);
      chk("vert_indx", {27'h0, mv_indx}, m);
      serve(exp_cmd(tbl[m], 1), 1, 0, "hor", got);
      if (m == 0) chk("first_hor", {16'h0, got}, 32'h5BF1);
    end
    @(negedge clk);
    send_resp = 1'b0;
    cmd_rdy_UART = 1'b0;
    chk("done_pulse", {31'h0, tour_done}, 32'h1);
    chk("done_idle", {31'h0, tour_busy}, 32'h0);
    chk("done_indx", {27'h0, mv_indx}, N - 1);
    chk("done_err", {31'h0, tour_err}, 32'h0);
    @(negedge clk);
    chk("done_once", {31'h0, tour_done}, 32'h0);
    repeat (2) @(negedge clk);
    chk("rdy_pulses", rdy_pulses, 2 * N);
    chk("done_pulses", done_pulses, 1);

    // Illegal move at index 5
    fill_tbl();
    tbl[5] = 8'b0000_0011;
    @(negedge clk);
    start_tour = 1'b1;
    for (int m = 0; m < 5; m++) begin
      serve(exp_cmd(tbl[m], 0), 2, 0, "ill_vert", got);
      serve(exp_cmd(tbl[m], 1), 1, 0, "ill_hor", got);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      send_resp = 1'b0;
      cmd_rdy_UART = 1'b0;
      chk("ill_no_rdy", {31'h0, cmd_rdy}, 32'h0);
    end
    chk("ill_err", {31'h0, tour_err}, 32'h1);
    chk("ill_idle", {31'h0, tour_busy}, 32'h0);
    chk("ill_indx", {27'h0, mv_indx}, 32'h5);
    chk("ill_done", done_pulses, 1);

    // Start with simultaneous abort, then abort in VERT_WAIT
    fill_tbl();
    @(negedge clk);
    start_tour = 1'b1;
    abort = 1'b1;
    serve(exp_cmd(tbl[0], 0), 2, 1, "abt_vert", got);
    chk("abt_err_clr", {31'h0, tour_err}, 32'h0);
    @(negedge clk);
    send_resp = 1'b0;
    cmd_rdy_UART = 1'b0;
    chk("abt_idle", {31'h0, tour_busy}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abt_no_hor", {31'h0, cmd_rdy}, 32'h0);
    end
    chk("abt_done", done_pulses, 1);
    chk("abt_err", {31'h0, tour_err}, 32'h0);

    // Reset while in HOR_WAIT of move 2
    fill_tbl();
    @(negedge clk);
    start_tour = 1'b1;
    for (int m = 0; m < 3; m++) begin
      serve(exp_cmd(tbl[m], 0), 2, 0, "rst_vert", got);
      serve(exp_cmd(tbl[m], 1), 1, 0, "rst_hor", got);
      if (m == 2) send_resp = 1'b0;
    end
    chk("rst_pre_indx", {27'h0, mv_indx}, 32'h2);
    dp = done_pulses;
    rst_n = 1'b0;
    cmd_UART = 16'h2345;
    cmd_rdy_UART = 1'b1;
    @(negedge clk);
    chk("mrst_indx", {27'h0, mv_indx}, 32'h0);
    chk("mrst_busy", {31'h0, tour_busy}, 32'h0);
    chk("mrst_rdy", {31'h0, cmd_rdy}, 32'h1);
    chk("mrst_cmd", {16'h0, cmd}, 32'h2345);
    rst_n = 1'b1;
    @(negedge clk);
    cmd_rdy_UART = 1'b0;
    #1;
    chk("mrst_follow", {31'h0, cmd_rdy}, 32'h0);
    repeat (2) @(negedge clk);
    chk("mrst_nodone", done_pulses, dp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
